qos_flow_ctrl_fsm: RTL and testbench

Parametrised flow-control controller for the QoS module's per-VC FIFO bank. It sequences RESET/INIT/IDLE/ACTIVE/ERROR. It turns level pause/continue requests from the scheduler into one-cycle per-channel strobes, with same-cycle conflict resolution. It declares an error only when a FIFO stays full for a configurable number of cycles. It sits between the FIFO bank status outputs and the PCIe flow-control packet generator.

---
 rtl/qos_pkg.sv | 15 +
 rtl/qos_flow_ctrl_fsm_if.sv | 32 +++
 rtl/qos_ch_edge.sv | 73 +++++++
 rtl/qos_flow_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_qos_flow_ctrl_fsm.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/qos_pkg.sv
// Shared constants for the QoS flow-control controller: default parameters and
// the 3-bit state encodings (kept as plain constants for legacy tooling).
package qos_pkg;

  localparam int NUM_CH_DEF       = 4;
  localparam int FULL_LIMIT_DEF   = 4;
  localparam int IDLE_TIMEOUT_DEF = 8;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd7;

endpackage

// File: rtl/qos_flow_ctrl_fsm_if.sv
// Bundle between the FIFO bank / scheduler (master) and the flow-control
// controller (slave).
interface qos_flow_ctrl_fsm_if
  import qos_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) ();

  logic              set_init;
  logic              err_clr;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] pause_fifos;
  logic [NUM_CH-1:0] continue_fifos;
  logic              init;
  logic              idle;
  logic [NUM_CH-1:0] pause_stb;
  logic [NUM_CH-1:0] continue_stb;
  logic [NUM_CH-1:0] error_full;
  logic [2:0]        state_o;

  modport master (
    output set_init, err_clr, empty, full, pause_fifos, continue_fifos,
    input  init, idle, pause_stb, continue_stb, error_full, state_o
  );

  modport slave (
    input  set_init, err_clr, empty, full, pause_fifos, continue_fifos,
    output init, idle, pause_stb, continue_stb, error_full, state_o
  );

endinterface

// File: rtl/qos_ch_edge.sv
// Per-channel request edge detection with deferred continue, plus the
// saturating consecutive-full counter that flags an overflow hit.
module qos_ch_edge
  import qos_pkg::*;
#(
  parameter int FULL_LIMIT = FULL_LIMIT_DEF
) (
  input  logic CLK,
  input  logic reset,
  input  logic count_en,
  input  logic strobe_en,
  input  logic pause_in,
  input  logic cont_in,
  input  logic full_in,
  output logic pause_stb_nxt,
  output logic cont_stb_nxt,
  output logic hit
);

  localparam int CW = $clog2(FULL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(FULL_LIMIT);

  logic          pause_hist;
  logic          cont_hist;
  logic          defer;
  logic          defer_nxt;
  logic          p_rise;
  logic          c_rise;
  logic          c_fall;
  logic [CW-1:0] full_cnt;
  logic [CW-1:0] full_cnt_nxt;

  // Kept apart from the edge logic: hit feeds the state decision that in turn
  // gates the strobes, so it must not depend on strobe_en.
  always_comb begin
    full_cnt_nxt = '0;
    if (count_en && full_in)
      full_cnt_nxt = (full_cnt == LIMIT) ? LIMIT : full_cnt + CW'(1);
    hit = count_en && (full_cnt_nxt == LIMIT);
  end

  // Pause beats a simultaneous continue; the losing continue is parked in
  // defer and issued on the first cycle without a pause edge.
  always_comb begin
    p_rise        = pause_in & ~pause_hist;
    c_rise        = cont_in & ~cont_hist;
    c_fall        = ~cont_in & cont_hist;
    pause_stb_nxt = strobe_en & p_rise;
    cont_stb_nxt  = strobe_en & (c_rise | defer) & ~p_rise;
    defer_nxt     = defer;
    if (!strobe_en)
      defer_nxt = 1'b0;
    else if (p_rise && c_rise)
      defer_nxt = 1'b1;
    else if (cont_stb_nxt || c_fall)
      defer_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pause_hist <= 1'b0;
      cont_hist  <= 1'b0;
      defer      <= 1'b0;
      full_cnt   <= '0;
    end else begin
      pause_hist <= pause_in;
      cont_hist  <= cont_in;
      defer      <= defer_nxt;
      full_cnt   <= full_cnt_nxt;
    end
  end

endmodule

// File: rtl/qos_flow_ctrl_fsm.sv
// Flow-control sequencer for the per-VC FIFO bank: state register, idle
// timeout counter and the registered strobe/status outputs.
module qos_flow_ctrl_fsm
  import qos_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int FULL_LIMIT   = FULL_LIMIT_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input logic                CLK,
  input logic                reset,
  qos_flow_ctrl_fsm_if.slave bus
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_TIMEOUT);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [IW-1:0]     idle_cnt;
  logic [IW-1:0]     idle_cnt_nxt;
  logic              all_empty;
  logic              count_en;
  logic              strobe_en;
  logic              timeout;
  logic              any_hit;
  logic [NUM_CH-1:0] hit_vec;
  logic [NUM_CH-1:0] pause_nxt;
  logic [NUM_CH-1:0] cont_nxt;
  logic              init_r;
  logic              idle_r;
  logic [NUM_CH-1:0] pause_stb_r;
  logic [NUM_CH-1:0] cont_stb_r;
  logic [NUM_CH-1:0] error_full_r;

  assign all_empty = &bus.empty;
  assign count_en  = (state == ST_ACTIVE);
  assign any_hit   = |hit_vec;
  assign strobe_en = count_en && (next_state != ST_ERROR);
  assign timeout   = count_en && (idle_cnt_nxt == IDLE_LIM);

  always_comb begin
    idle_cnt_nxt = '0;
    if (count_en && all_empty)
      idle_cnt_nxt = (idle_cnt == IDLE_LIM) ? IDLE_LIM : idle_cnt + IW'(1);
  end

  // A full overflow outranks the idle timeout when both land together.
  always_comb begin
    next_state = ST_RESET;
    case (state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   next_state = bus.set_init ? ST_INIT : ST_IDLE;
      ST_IDLE:   next_state = all_empty ? ST_IDLE : ST_ACTIVE;
      ST_ACTIVE: begin
        if (any_hit)
          next_state = ST_ERROR;
        else if (timeout)
          next_state = ST_IDLE;
        else
          next_state = ST_ACTIVE;
      end
      ST_ERROR:  next_state = bus.err_clr ? ST_INIT : ST_ERROR;
      default:   next_state = ST_RESET;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    qos_ch_edge #(
      .FULL_LIMIT(FULL_LIMIT)
    ) u_ch (
      .CLK           (CLK),
      .reset         (reset),
      .count_en      (count_en),
      .strobe_en     (strobe_en),
      .pause_in      (bus.pause_fifos[g]),
      .cont_in       (bus.continue_fifos[g]),
      .full_in       (bus.full[g]),
      .pause_stb_nxt (pause_nxt[g]),
      .cont_stb_nxt  (cont_nxt[g]),
      .hit           (hit_vec[g])
    );
  end

  // Outputs are registered against next_state so status and state_o move on
  // the same edge; error_full captures the offending mask on ERROR entry.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= ST_RESET;
      idle_cnt     <= '0;
      init_r       <= 1'b0;
      idle_r       <= 1'b0;
      pause_stb_r  <= '0;
      cont_stb_r   <= '0;
      error_full_r <= '0;
    end else begin
      state       <= next_state;
      idle_cnt    <= idle_cnt_nxt;
      init_r      <= (next_state == ST_INIT) && bus.set_init;
      idle_r      <= (next_state == ST_IDLE) && all_empty;
      pause_stb_r <= pause_nxt;
      cont_stb_r  <= cont_nxt;
      if (next_state != ST_ERROR)
        error_full_r <= '0;
      else if (state == ST_ACTIVE)
        error_full_r <= hit_vec;
    end
  end

  assign bus.state_o      = state;
  assign bus.init         = init_r;
  assign bus.idle         = idle_r;
  assign bus.pause_stb    = pause_stb_r;
  assign bus.continue_stb = cont_stb_r;
  assign bus.error_full   = error_full_r;

endmodule

// File: tb/tb_qos_flow_ctrl_fsm.sv
// Scenario bench for qos_flow_ctrl_fsm: expected output vectors are queued as
// each stimulus cycle is applied and compared once the clock edge has passed.
module tb_qos_flow_ctrl_fsm;
  import qos_pkg::*;

  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  logic [16:0] exp_q[$];
  logic [16:0] want;

  always #5 CLK = ~CLK;

  qos_flow_ctrl_fsm_if #(.NUM_CH(4)) bus ();

  qos_flow_ctrl_fsm #(
    .NUM_CH(4), .FULL_LIMIT(4), .IDLE_TIMEOUT(8)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Output vector layout: {state, init, idle, pause_stb, continue_stb, error_full}
  function automatic logic [16:0] pk(input logic [2:0] st, input logic in,
                                     input logic id, input logic [3:0] ps,
                                     input logic [3:0] cs, input logic [3:0] ef);
    return {st, in, id, ps, cs, ef};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.state_o, bus.init, bus.idle, bus.pause_stb, bus.continue_stb, bus.error_full};
  endfunction

  // Inputs are already driven; record what the next edge must produce.
  task automatic apply_stimulus(input logic [16:0] expected);
    exp_q.push_back(expected);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.set_init = 1'b1;
    bus.err_clr = 1'b0;
    bus.empty = 4'hF;
    bus.full = 4'h0;
    bus.pause_fifos = 4'h0;
    bus.continue_fifos = 4'h0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) reset = 1'b0;
      if (k == 5) bus.set_init = 1'b0;
      if (k < 3)       apply_stimulus(pk(ST_RESET, 0, 0, 4'h0, 4'h0, 4'h0));
      else if (k < 5)  apply_stimulus(pk(ST_INIT, 1, 0, 4'h0, 4'h0, 4'h0));
      else             apply_stimulus(pk(ST_IDLE, 0, 1, 4'h0, 4'h0, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL reset_init[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
  endtask

  task automatic test_pause_edge();
    bus.empty = 4'hE;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) bus.pause_fifos = 4'b0101;
      if (k == 6) bus.pause_fifos = 4'b0000;
      apply_stimulus(pk(ST_ACTIVE, 0, 0, (k == 1) ? 4'b0101 : 4'b0000, 4'h0, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL pause_edge[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
  endtask

  task automatic test_conflict();
    logic [3:0] ps;
    logic [3:0] cs;
    for (int k = 0; k < 7; k++) begin
      ps = 4'h0;
      cs = 4'h0;
      case (k)
        0: begin bus.pause_fifos = 4'b0010; bus.continue_fifos = 4'b0010; ps = 4'b0010; end
        1: cs = 4'b0010;
        3: begin bus.pause_fifos = 4'b0000; bus.continue_fifos = 4'b0000; end
        4: begin bus.continue_fifos = 4'b0001; cs = 4'b0001; end
        6: bus.continue_fifos = 4'b0000;
        default: ;
      endcase
      apply_stimulus(pk(ST_ACTIVE, 0, 0, ps, cs, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL conflict[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      bus.pause_fifos = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      apply_stimulus(pk(ST_ACTIVE, 0, 0, (k % 2 == 0) ? 4'b1000 : 4'b0000, 4'h0, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL back_to_back[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
    bus.err_clr = 1'b1;
    apply_stimulus(pk(ST_ACTIVE, 0, 0, 4'h0, 4'h0, 4'h0));
    bus.err_clr = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (observed() !== want)
      $display("[TB] FAIL err_clr_ignored got=%h want=%h", observed(), want);
    else passes++;
  endtask

  task automatic test_full_error();
    for (int k = 0; k < 14; k++) begin
      case (k)
        0:  bus.full = 4'b0100;
        3:  bus.full = 4'b0000;
        4:  bus.full = 4'b0100;
        8:  begin bus.full = 4'b0000; bus.pause_fifos = 4'b0001; end
        10: bus.err_clr = 1'b1;
        11: bus.err_clr = 1'b0;
        13: bus.pause_fifos = 4'b0000;
        default: ;
      endcase
      if (k < 7)       apply_stimulus(pk(ST_ACTIVE, 0, 0, 4'h0, 4'h0, 4'h0));
      else if (k < 10) apply_stimulus(pk(ST_ERROR, 0, 0, 4'h0, 4'h0, 4'b0100));
      else if (k == 10) apply_stimulus(pk(ST_INIT, 0, 0, 4'h0, 4'h0, 4'h0));
      else if (k == 11) apply_stimulus(pk(ST_IDLE, 0, 0, 4'h0, 4'h0, 4'h0));
      else             apply_stimulus(pk(ST_ACTIVE, 0, 0, 4'h0, 4'h0, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL full_error[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
  endtask

  task automatic test_idle_timeout();
    for (int k = 0; k < 13; k++) begin
      bus.empty = (k == 4) ? 4'hE : 4'hF;
      if (k == 12) apply_stimulus(pk(ST_IDLE, 0, 1, 4'h0, 4'h0, 4'h0));
      else         apply_stimulus(pk(ST_ACTIVE, 0, 0, 4'h0, 4'h0, 4'h0));
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL idle_timeout[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
  endtask

  task automatic test_preload();
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: bus.empty = 4'hE;
        1: begin reset = 1'b1; bus.err_clr = 1'b1; bus.set_init = 1'b1; bus.pause_fifos = 4'hF; end
        2: begin reset = 1'b0; bus.err_clr = 1'b0; end
        3: begin bus.set_init = 1'b0; bus.empty = 4'hF; end
        4: bus.empty = 4'hE;
        default: ;
      endcase
      case (k)
        1:       apply_stimulus(pk(ST_RESET, 0, 0, 4'h0, 4'h0, 4'h0));
        2:       apply_stimulus(pk(ST_INIT, 1, 0, 4'h0, 4'h0, 4'h0));
        3:       apply_stimulus(pk(ST_IDLE, 0, 1, 4'h0, 4'h0, 4'h0));
        default: apply_stimulus(pk(ST_ACTIVE, 0, 0, 4'h0, 4'h0, 4'h0));
      endcase
      want = exp_q.pop_front();
      checks++;
      if (observed() !== want)
        $display("[TB] FAIL preload[%0d] got=%h want=%h", k, observed(), want);
      else passes++;
    end
    bus.pause_fifos = 4'h0;
  endtask

  initial begin
    test_reset();
    test_pause_edge();
    test_conflict();
    test_back_to_back();
    test_full_error();
    test_idle_timeout();
    test_preload();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
